// File: rtl/params_pkg.sv
// Datapath-wide widths shared by the Dilithium arithmetic blocks.
package params_pkg;
  localparam int DATA_LENGTH = 24;
endpackage

// File: rtl/reduction_seq_pkg.sv
// Types and default constants for the reduction-core sequencer.
package reduction_seq_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT,
    ST_DONE
  } seq_state_t;

  localparam int DEF_N_COEFF = 256;
  localparam int DEF_MOD     = 8380417;
  localparam int DEF_TIMEOUT = 64;
endpackage

// File: rtl/reduction_watchdog.sv
// WAIT-state timer: clr_i zeroes it, en_i advances it, expire_o flags TIMEOUT-1.
// Combinational expire from the count register; no handshake.
module reduction_watchdog
  import reduction_seq_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count_q, count_d;

  assign expire_o = (count_q == CNT_W'(TIMEOUT - 1));

  // Holds at the expiry value so the count never wraps back to zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !expire_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/reduction_sequencer.sv
// Feeds one coefficient at a time to the reduction core (start pulse, wait for valid); L+3 cycles each.
// Input is accepted only in LOAD; a stalled result holds OUT, so nothing new is issued until m_ready_i.
module reduction_sequencer
  import reduction_seq_pkg::*;
#(
  parameter int DATA_LENGTH = params_pkg::DATA_LENGTH,
  parameter int N_COEFF     = DEF_N_COEFF,
  parameter int MOD         = DEF_MOD,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  input  logic [DATA_LENGTH-1:0]     s_data_i,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  output logic                       red_start_o,
  output logic [DATA_LENGTH-1:0]     red_x_o,
  output logic [DATA_LENGTH-1:0]     red_m_o,
  input  logic [DATA_LENGTH-1:0]     red_result_i,
  input  logic                       red_valid_i,
  output logic [DATA_LENGTH-1:0]     m_data_o,
  output logic [$clog2(N_COEFF)-1:0] m_idx_o,
  output logic                       m_valid_o,
  input  logic                       m_ready_i
);

  localparam int IDX_W = $clog2(N_COEFF);

  seq_state_t             state_q;
  logic [DATA_LENGTH-1:0] x_q;
  logic [DATA_LENGTH-1:0] data_q;
  logic [IDX_W-1:0]       idx_q;
  logic [IDX_W-1:0]       m_idx_q;
  logic                   err_q;
  logic                   wd_expire;

  reduction_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_q == ST_ISSUE),
    .en_i     (state_q == ST_WAIT),
    .expire_o (wd_expire)
  );

  // All handshake/status outputs are decodes of the state register.
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign s_ready_o   = (state_q == ST_LOAD);
  assign red_start_o = (state_q == ST_ISSUE);
  assign m_valid_o   = (state_q == ST_OUT);
  assign err_o       = err_q;
  assign red_x_o     = x_q;
  assign red_m_o     = DATA_LENGTH'(MOD);
  assign m_data_o    = data_q;
  assign m_idx_o     = m_idx_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      m_idx_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            idx_q   <= '0;
            err_q   <= 1'b0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (s_valid_i) begin
            x_q     <= s_data_i;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          // A valid in the final timer cycle still wins over the timeout.
          if (red_valid_i) begin
            data_q  <= red_result_i;
            m_idx_q <= idx_q;
            state_q <= ST_OUT;
          end else if (wd_expire) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_OUT: begin
          if (m_ready_i) begin
            if (idx_q == IDX_W'(N_COEFF - 1)) begin
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= ST_LOAD;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reduction_sequencer.sv
// Bench for reduction_sequencer: table-driven blocks against an L=3 core model returning x % MOD.
module tb_reduction_sequencer;
  localparam int DL   = params_pkg::DATA_LENGTH;
  localparam int N    = 4;
  localparam int IW   = $clog2(N);
  localparam int MODV = 8380417;
  localparam int TMO  = 64;
  localparam int L    = 3;

  typedef struct {
    int x;
    int exp;
  } vec_t;

  typedef struct {
    logic [DL-1:0] d;
    logic [IW-1:0] idx;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          busy_o, done_o, err_o;
  logic [DL-1:0] s_data_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic          red_start_o;
  logic [DL-1:0] red_x_o, red_m_o, red_result_i;
  logic          red_valid_i;
  logic [DL-1:0] m_data_o;
  logic [IW-1:0] m_idx_o;
  logic          m_valid_o;
  logic          m_ready_i = 1'b1;

  // Core model plus an independent stray-valid injector.
  logic          core_vld = 1'b0;
  logic [DL-1:0] core_res = '0;
  logic [DL-1:0] core_x = '0;
  int            core_cnt = 0;
  logic          core_dead = 1'b0;
  logic          stray_vld = 1'b0;
  logic [DL-1:0] stray_res = '0;

  assign red_valid_i  = core_vld | stray_vld;
  assign red_result_i = stray_vld ? stray_res : core_res;

  reduction_sequencer #(
    .N_COEFF (N)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .s_data_i     (s_data_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .red_start_o  (red_start_o),
    .red_x_o      (red_x_o),
    .red_m_o      (red_m_o),
    .red_result_i (red_result_i),
    .red_valid_i  (red_valid_i),
    .m_data_o     (m_data_o),
    .m_idx_o      (m_idx_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    core_vld <= 1'b0;
    if (red_start_o) begin
      core_cnt <= L;
      core_x   <= red_x_o;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1 && !core_dead) begin
        core_vld <= 1'b1;
        core_res <= DL'(core_x % MODV);
      end
    end
  end

  // Passive monitor: records output handshakes and protocol events.
  logic [DL-1:0] act_d[256];
  logic [IW-1:0] act_i[256];
  int            act_c[256];
  int            act_wr = 0;
  int            done_cnt = 0;
  int            start_cnt = 0;
  logic          prev_start = 1'b0;
  logic          rm_bad = 1'b0;
  logic          inv_bad = 1'b0;

  always @(negedge clk) begin
    prev_start <= red_start_o;
    if (red_m_o !== DL'(MODV)) rm_bad <= 1'b1;
    if (red_start_o && (prev_start || m_valid_o)) inv_bad <= 1'b1;
    if (red_start_o) start_cnt <= start_cnt + 1;
    if (done_o) done_cnt <= done_cnt + 1;
    if (m_valid_o && m_ready_i) begin
      act_d[act_wr % 256] <= m_data_o;
      act_i[act_wr % 256] <= m_idx_o;
      act_c[act_wr % 256] <= cyc;
      act_wr <= act_wr + 1;
    end
  end

  int   tests_run = 0;
  int   tests_failed = 0;
  int   act_rd = 0;
  exp_t sb[$];
  int   out_cyc[$];
  vec_t tbl[16];
  logic feed_to = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (act_rd != act_wr) begin
      check("sb_has_entry_for_output", 64'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_data", 64'(act_d[act_rd % 256]), 64'(e.d));
        check("out_idx", 64'(act_i[act_rd % 256]), 64'(e.idx));
      end
      out_cyc.push_back(act_c[act_rd % 256]);
      act_rd++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic feed(input int base, input int n, input bit push);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      s_data_i  = DL'(tbl[base + k].x);
      s_valid_i = 1'b1;
      for (int w = 0; w < 300 && !s_ready_o; w++) begin
        @(posedge clk);
        #1;
      end
      if (!s_ready_o) begin
        feed_to   = 1'b1;
        s_valid_i = 1'b0;
        return;
      end
      if (push) begin
        e.d   = DL'(tbl[base + k].exp);
        e.idx = IW'(k);
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      s_valid_i = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic end_blk(input int d0, input int s0, input int o0);
    for (int w = 0; w < 400 && done_cnt == d0; w++) tick();
    tick();
    check("block_done_in_time", 64'(done_cnt != d0), 1);
    check("block_done_pulses", 64'(done_cnt - d0), 1);
    check("block_outputs", 64'(act_wr - o0), N);
    check("block_core_starts", 64'(start_cnt - s0), N);
    check("block_sb_empty", 64'(sb.size()), 0);
    check("block_feed_timeout", 64'(feed_to), 0);
    check("block_idle_after", 64'(busy_o), 0);
  endtask

  task automatic check_idle_outputs();
    check("idle_busy", 64'(busy_o), 0);
    check("idle_done", 64'(done_o), 0);
    check("idle_err", 64'(err_o), 0);
    check("idle_s_ready", 64'(s_ready_o), 0);
    check("idle_red_start", 64'(red_start_o), 0);
    check("idle_red_x", 64'(red_x_o), 0);
    check("idle_m_data", 64'(m_data_o), 0);
    check("idle_m_idx", 64'(m_idx_o), 0);
    check("idle_m_valid", 64'(m_valid_o), 0);
    check("idle_red_m", 64'(red_m_o), MODV);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got cycle %0d, required finish earlier", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int   d0, s0, o0, wcnt;
    logic [DL-1:0] sd;
    logic [IW-1:0] si;
    logic bp_bad, bp_to;

    tbl = '{'{1, 1}, '{8380417, 0}, '{8380418, 1}, '{16760836, 2},
            '{0, 0}, '{8380416, 8380416}, '{16777215, 16381}, '{12345678, 3965261},
            '{5, 5}, '{8380420, 3}, '{16760834, 0}, '{100, 100},
            '{7, 7}, '{9000000, 619583}, '{4194304, 4194304}, '{16700000, 8319583}};

    repeat (3) tick();
    check_idle_outputs();
    rst_i = 1'b0;
    tick();

    // Nominal block with back-to-back throughput.
    d0 = done_cnt; s0 = start_cnt; o0 = act_wr; out_cyc.delete();
    pulse_start();
    check("nominal_busy", 64'(busy_o), 1);
    check("nominal_load_ready", 64'(s_ready_o), 1);
    feed(0, N, 1);
    end_blk(d0, s0, o0);
    check("nominal_out_count", 64'(out_cyc.size()), N);
    for (int k = 1; k < out_cyc.size(); k++)
      check("nominal_period", 64'(out_cyc[k] - out_cyc[k-1]), L + 3);

    // Output backpressure on the first result.
    d0 = done_cnt; s0 = start_cnt; o0 = act_wr;
    bp_bad = 1'b0; bp_to = 1'b0; sd = '0; si = '1;
    m_ready_i = 1'b0;
    pulse_start();
    fork
      feed(4, N, 1);
      begin
        for (int w = 0; w < 300 && !m_valid_o; w++) begin
          @(posedge clk);
          #1;
        end
        if (!m_valid_o) bp_to = 1'b1;
        sd = m_data_o;
        si = m_idx_o;
        repeat (5) begin
          @(posedge clk);
          #1;
          if (m_data_o !== sd || m_idx_o !== si || !m_valid_o || s_ready_o || red_start_o)
            bp_bad = 1'b1;
        end
        m_ready_i = 1'b1;
      end
    join
    check("bp_valid_seen", 64'(bp_to), 0);
    check("bp_stall_stable", 64'(bp_bad), 0);
    check("bp_stalled_data", 64'(sd), 64'(tbl[4].exp));
    check("bp_stalled_idx", 64'(si), 0);
    end_blk(d0, s0, o0);

    // Timeout: core never answers; count the WAIT cycles.
    core_dead = 1'b1;
    d0 = done_cnt; o0 = act_wr;
    pulse_start();
    feed(8, 1, 0);
    check("to_issue_pulse", 64'(red_start_o), 1);
    wcnt = 0;
    for (int w = 0; w < 200 && busy_o; w++) begin
      tick();
      if (busy_o) wcnt++;
    end
    check("to_wait_cycles", 64'(wcnt), TMO);
    check("to_err_set", 64'(err_o), 1);
    check("to_busy_clear", 64'(busy_o), 0);
    check("to_no_done", 64'(done_cnt - d0), 0);
    check("to_no_output", 64'(act_wr - o0), 0);
    tick();
    check("to_err_sticky", 64'(err_o), 1);
    core_dead = 1'b0;
    d0 = done_cnt; s0 = start_cnt; o0 = act_wr; feed_to = 1'b0;
    pulse_start();
    check("to_err_cleared_by_start", 64'(err_o), 0);
    feed(8, N, 1);
    end_blk(d0, s0, o0);

    // Stray core valid in IDLE and LOAD.
    d0 = done_cnt; s0 = start_cnt; o0 = act_wr;
    stray_res = DL'(77);
    stray_vld = 1'b1;
    tick();
    stray_vld = 1'b0;
    check("stray_idle_no_valid", 64'(m_valid_o), 0);
    check("stray_idle_busy", 64'(busy_o), 0);
    pulse_start();
    stray_vld = 1'b1;
    tick();
    stray_vld = 1'b0;
    check("stray_load_still_ready", 64'(s_ready_o), 1);
    check("stray_load_no_valid", 64'(m_valid_o), 0);
    check("stray_load_no_start", 64'(red_start_o), 0);
    feed(12, N, 1);
    end_blk(d0, s0, o0);

    // Reset during WAIT; the core's late valid must be dropped.
    pulse_start();
    feed(0, 1, 0);
    tick();
    check("rst_in_wait_busy", 64'(busy_o), 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_idle_outputs();
    o0 = act_wr;
    repeat (6) tick();
    check("rst_late_valid_ignored", 64'(act_wr - o0), 0);
    check("rst_stays_idle", 64'(busy_o), 0);
    d0 = done_cnt; s0 = start_cnt; o0 = act_wr;
    pulse_start();
    feed(0, N, 1);
    end_blk(d0, s0, o0);

    // start_i held high from LOAD through DONE.
    d0 = done_cnt; s0 = start_cnt; o0 = act_wr;
    start_i = 1'b1;
    tick();
    fork
      feed(4, N, 1);
      begin
        for (int w = 0; w < 400 && !done_o; w++) begin
          @(posedge clk);
          #1;
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
      end
    join
    end_blk(d0, s0, o0);

    check("red_m_constant", 64'(rm_bad), 0);
    check("single_outstanding_request", 64'(inv_bad), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
